// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Sequences one multiply/divide op from the EX stage into an external
// multiplier or divider, holds the pipeline while the unit works, and hands
// the result back to EX. A flushed op is drained (its result is thrown away)
// so that a late done from the unit cannot be mistaken for a newer op.
//
// Optional build macro: MULDIV_DIV0_FASTPATH_EN
//   When defined, a divide by zero is answered locally in one cycle without
//   starting the divider. When undefined, it goes to the divider as usual.
//
// Handshake (valid/ready):
//   - EX presents an op with req_valid=1 and keeps it stable while
//     func_stall=1. In IDLE the op is accepted on any cycle with
//     req_valid=1 and flush=0; flush always wins over req_valid.
//   - unit_start is a one-cycle pulse in the first BUSY cycle. The selected
//     unit answers with a one-cycle done (mul_done or div_done) together
//     with unit_result, no earlier than the cycle after unit_start. A done
//     from the unselected unit, or any done outside BUSY/DRAIN, is ignored.
//   - result is valid while result_valid=1 and is consumed on the first
//     result_valid cycle with ex_stall=0 (or dropped on flush).
//   - state_dbg exposes the FSM state: 0 IDLE, 1 BUSY, 2 DRAIN, 3 DONE.
module muldiv_sequencer #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_is_div,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        flush,
   input  logic        ex_stall,
   output logic        unit_start,
   output logic        unit_sel,
   output logic [2:0]  unit_funct3,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   input  logic        mul_done,
   input  logic        div_done,
   input  logic [31:0] unit_result,
   output logic [31:0] result,
   output logic        result_valid,
   output logic        func_stall,
   output logic        timeout_err,
   output logic [1:0]  state_dbg
);

   // Counter must be able to hold the value TIMEOUT itself.
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [CW-1:0]   cnt_q;

   logic            issue;          // op accepted this cycle
   logic            fast_div0;      // op answered locally, no unit start
   logic            start_unit;     // op sent to a unit this cycle
   logic            sel_done;       // done from the unit that owns the op
   logic            busy_done;      // sel_done outside the start cycle
   logic            cnt_last;       // this BUSY/DRAIN cycle reaches TIMEOUT
   logic            busy_timeout;
   logic            drain_timeout;
   logic            capture;

   assign issue      = (state_q == S_IDLE) && req_valid && !flush;
   assign sel_done   = unit_sel ? div_done : mul_done;
   // The unit cannot have finished in the cycle it was started.
   assign busy_done  = sel_done && !unit_start;
   assign cnt_last   = (cnt_q == CW'(TIMEOUT - 1));

`ifdef MULDIV_DIV0_FASTPATH_EN
   logic [31:0] div0_value;
   assign fast_div0  = issue && req_is_div && (req_b == 32'd0);
   // DIV/DIVU (funct3[1]=0) give all ones, REM/REMU give the dividend.
   assign div0_value = req_funct3[1] ? req_a : 32'hFFFF_FFFF;
`else
   assign fast_div0  = 1'b0;
`endif

   assign start_unit    = issue && !fast_div0;
   assign busy_timeout  = (state_q == S_BUSY)  && !busy_done && cnt_last;
   assign drain_timeout = (state_q == S_DRAIN) && !sel_done  && cnt_last;
   assign capture       = (state_q == S_BUSY)  && busy_done  && !flush;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (issue) begin
               state_d = fast_div0 ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (flush) begin
               // A kill that coincides with the unit finishing (or timing
               // out) has nothing left to wait for.
               state_d = (busy_done || cnt_last) ? S_IDLE : S_DRAIN;
            end else if (busy_done || cnt_last) begin
               state_d = S_DONE;
            end
         end
         S_DRAIN: begin
            if (sel_done || cnt_last) begin
               state_d = S_IDLE;
            end
         end
         S_DONE: begin
            if (flush || !ex_stall) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the current state.
   always_comb begin
      func_stall   = 1'b0;
      result_valid = 1'b0;
      state_dbg    = state_q;
      case (state_q)
         S_IDLE:  func_stall   = req_valid && !flush;
         S_BUSY:  func_stall   = 1'b1;
         S_DRAIN: func_stall   = req_valid;
         S_DONE:  result_valid = 1'b1;
         default: func_stall   = 1'b0;
      endcase
   end

   // Operand latch and start pulse; operands stay put until the next issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unit_start  <= 1'b0;
         unit_sel    <= 1'b0;
         unit_funct3 <= 3'd0;
         unit_a      <= 32'd0;
         unit_b      <= 32'd0;
      end else begin
         unit_start <= start_unit;
         if (issue) begin
            unit_sel    <= req_is_div;
            unit_funct3 <= req_funct3;
            unit_a      <= req_a;
            unit_b      <= req_b;
         end
      end
   end

   // Cycle counter: cleared when an op goes to a unit, counts BUSY/DRAIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (start_unit) begin
         cnt_q <= '0;
      end else if ((state_q == S_BUSY) || (state_q == S_DRAIN)) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // Result register: unit answer, local divide-by-zero answer, or zero on
   // timeout. Held unchanged otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= 32'd0;
`ifdef MULDIV_DIV0_FASTPATH_EN
      end else if (fast_div0) begin
         result <= div0_value;
`endif
      end else if (capture) begin
         result <= unit_result;
      end else if (busy_timeout || drain_timeout) begin
         result <= 32'd0;
      end
   end

   // Sticky timeout flag, only cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_err <= 1'b0;
      end else if (busy_timeout || drain_timeout) begin
         timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer. The bench plays the role of the
// EX stage and of both arithmetic units. Expected results come from a plain
// arithmetic unit model; timing expectations come from the op scenario
// (issue cycle, unit delay, stall and flush choices).
// Honours MULDIV_DIV0_FASTPATH_EN the same way the design does.
module tb_muldiv_sequencer;

   localparam int PERIOD = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_is_div = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_a = 32'd0;
   logic [31:0] req_b = 32'd0;
   logic        flush = 1'b0;
   logic        ex_stall = 1'b0;
   logic        mul_done = 1'b0;
   logic        div_done = 1'b0;
   logic [31:0] unit_result = 32'd0;

   logic        unit_start, unit_sel, result_valid, func_stall, timeout_err;
   logic [2:0]  unit_funct3;
   logic [31:0] unit_a, unit_b, result;
   logic [1:0]  state_dbg;

   logic        t8_unit_start, t8_unit_sel, t8_result_valid, t8_func_stall, t8_timeout_err;
   logic [2:0]  t8_unit_funct3;
   logic [31:0] t8_unit_a, t8_unit_b, t8_result;
   logic [1:0]  t8_state_dbg;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic        rv_prev = 1'b0;

   muldiv_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_is_div(req_is_div), .req_funct3(req_funct3),
      .req_a(req_a), .req_b(req_b), .flush(flush), .ex_stall(ex_stall),
      .unit_start(unit_start), .unit_sel(unit_sel), .unit_funct3(unit_funct3),
      .unit_a(unit_a), .unit_b(unit_b),
      .mul_done(mul_done), .div_done(div_done), .unit_result(unit_result),
      .result(result), .result_valid(result_valid), .func_stall(func_stall),
      .timeout_err(timeout_err), .state_dbg(state_dbg)
   );

   muldiv_sequencer #(.TIMEOUT(8)) dut_to (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_is_div(req_is_div), .req_funct3(req_funct3),
      .req_a(req_a), .req_b(req_b), .flush(flush), .ex_stall(ex_stall),
      .unit_start(t8_unit_start), .unit_sel(t8_unit_sel), .unit_funct3(t8_unit_funct3),
      .unit_a(t8_unit_a), .unit_b(t8_unit_b),
      .mul_done(mul_done), .div_done(div_done), .unit_result(unit_result),
      .result(t8_result), .result_valid(t8_result_valid), .func_stall(t8_func_stall),
      .timeout_err(t8_timeout_err), .state_dbg(t8_state_dbg)
   );

   // Clock and watchdog.
   always #(PERIOD / 2) clk = ~clk;

   initial begin
      #(PERIOD * 20000);
      $display("FAIL watchdog: simulation did not finish within %0d cycles", 20000);
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference arithmetic unit: what the attached multiplier/divider returns.
   function automatic logic [31:0] unit_model(input logic is_div, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] b);
      if (!is_div) return a * b;
      if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
      return f3[1] ? (a % b) : (a / b);
   endfunction

   // Scoreboard: every rising result_valid must deliver the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && result_valid && !rv_prev) begin
         if (exp_q.size() == 0) check_eq("sb_unexpected_result", 32'd1, 32'd0);
         else check_eq("sb_result", result, exp_q.pop_front());
      end
      rv_prev = result_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = 1'b0; req_is_div = 1'b0; req_funct3 = 3'd0; req_a = 32'd0; req_b = 32'd0;
      flush = 1'b0; ex_stall = 1'b0; mul_done = 1'b0; div_done = 1'b0; unit_result = 32'd0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // Unit side of one BUSY/DRAIN cycle j of an op that finishes at cycle d.
   task automatic drive_units(input logic is_div, input int j, input int d, input logic [31:0] val);
      logic sel, other;
      other = 1'($urandom_range(0, 1));
      if (j == d) begin
         sel = 1'b1; unit_result = val;
      end else if (j == 0) begin
         sel = 1'($urandom_range(0, 1)); unit_result = $urandom;
      end else begin
         sel = 1'b0; unit_result = $urandom;
      end
      if (is_div) begin div_done = sel; mul_done = other; end
      else begin mul_done = sel; div_done = other; end
   endtask

   // One op from issue to return to IDLE. d: cycles from unit_start to done.
   // flush_at: BUSY cycle index (< d) carrying a flush, or -1.
   task automatic run_op(input logic is_div, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int d, input int stall_n,
                         input int flush_at, input logic flush_done);
      logic [31:0] exp_res;
      logic        fast, killed, leave;
      exp_res = unit_model(is_div, f3, a, b);
      fast = 1'b0;
      killed = 1'b0;
`ifdef MULDIV_DIV0_FASTPATH_EN
      fast = is_div && (b == 32'd0);
`endif
      req_valid = 1'b1; req_is_div = is_div; req_funct3 = f3; req_a = a; req_b = b;
      #1;
      check_eq("issue_stall", 32'(func_stall), 32'd1);
      check_eq("issue_rv", 32'(result_valid), 32'd0);
      if (fast) exp_q.push_back(exp_res);
      tick();
      if (fast) begin
         check_eq("fast_no_start", 32'(unit_start), 32'd0);
      end else begin
         for (int j = 0; j <= d; j++) begin
            check_eq("busy_start", 32'(unit_start), 32'(j == 0));
            check_eq("busy_sel", 32'(unit_sel), 32'(is_div));
            check_eq("busy_funct3", 32'(unit_funct3), 32'(f3));
            check_eq("busy_a", unit_a, a);
            check_eq("busy_b", unit_b, b);
            check_eq("busy_rv", 32'(result_valid), 32'd0);
            check_eq("busy_stall", 32'(func_stall), 32'd1);
            drive_units(is_div, j, d, exp_res);
            if (j == flush_at) flush = 1'b1;
            else if (j == d) exp_q.push_back(exp_res);
            tick();
            flush = 1'b0; mul_done = 1'b0; div_done = 1'b0;
            if (j == flush_at) begin
               killed = 1'b1;
               break;
            end
         end
         if (killed) begin
            for (int j = flush_at + 1; j <= d; j++) begin
               req_valid = 1'($urandom_range(0, 1));
               #1;
               check_eq("drain_stall", 32'(func_stall), 32'(req_valid));
               check_eq("drain_rv", 32'(result_valid), 32'd0);
               check_eq("drain_start", 32'(unit_start), 32'd0);
               check_eq("drain_a", unit_a, a);
               drive_units(is_div, j, d, $urandom);
               tick();
               mul_done = 1'b0; div_done = 1'b0;
            end
            req_valid = 1'b0;
            #1;
            check_eq("drain_idle_rv", 32'(result_valid), 32'd0);
            check_eq("drain_idle_stall", 32'(func_stall), 32'd0);
            return;
         end
      end
      for (int k = 0; k <= stall_n; k++) begin
         check_eq("done_rv", 32'(result_valid), 32'd1);
         check_eq("done_result", result, exp_res);
         check_eq("done_stall", 32'(func_stall), 32'd0);
         mul_done = 1'($urandom_range(0, 1));
         div_done = 1'($urandom_range(0, 1));
         unit_result = $urandom;
         ex_stall = (k < stall_n);
         flush = flush_done && (k == 0);
         leave = flush || !ex_stall;
         tick();
         flush = 1'b0; ex_stall = 1'b0; mul_done = 1'b0; div_done = 1'b0;
         if (leave) break;
      end
      req_valid = 1'b0;
      #1;
      check_eq("idle_rv", 32'(result_valid), 32'd0);
      check_eq("idle_stall", 32'(func_stall), 32'd0);
   endtask

   // One IDLE cycle with stray dones and possibly a flushed request.
   task automatic idle_cycle();
      logic rv, fl;
      rv = 1'($urandom_range(0, 1));
      fl = rv;
      req_valid = rv; flush = fl; req_is_div = 1'($urandom_range(0, 1));
      mul_done = 1'($urandom_range(0, 1)); div_done = 1'($urandom_range(0, 1));
      unit_result = $urandom;
      #1;
      check_eq("idle_flush_stall", 32'(func_stall), 32'(rv && !fl));
      tick();
      clear_inputs();
      check_eq("idle_no_start", 32'(unit_start), 32'd0);
      check_eq("idle_no_rv", 32'(result_valid), 32'd0);
   endtask

   initial begin
      logic        dv, fd;
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          d, st, fa;

      // Reset state while rst_n is held low.
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_start", 32'(unit_start), 32'd0);
      check_eq("rst_sel", 32'(unit_sel), 32'd0);
      check_eq("rst_funct3", 32'(unit_funct3), 32'd0);
      check_eq("rst_a", unit_a, 32'd0);
      check_eq("rst_b", unit_b, 32'd0);
      check_eq("rst_result", result, 32'd0);
      check_eq("rst_rv", 32'(result_valid), 32'd0);
      check_eq("rst_terr", 32'(timeout_err), 32'd0);
      check_eq("rst_stall_idle", 32'(func_stall), 32'd0);
      req_valid = 1'b1;
      #1;
      check_eq("rst_stall_req", 32'(func_stall), 32'd1);
      do_reset();

      // MUL 7*6, done one cycle after start.
      run_op(1'b0, 3'b000, 32'd7, 32'd6, 1, 0, -1, 1'b0);
      // DIV 100/7, done 33 cycles after start, three stalled DONE cycles.
      run_op(1'b1, 3'b100, 32'd100, 32'd7, 33, 3, -1, 1'b0);
      // DIV flushed two cycles after issue, done 10 cycles later, then a MUL.
      run_op(1'b1, 3'b100, 32'd100, 32'd7, 11, 0, 1, 1'b0);
      run_op(1'b0, 3'b000, 32'd9, 32'd9, 2, 0, -1, 1'b0);
      // Divide by zero: DIVU and REMU.
      run_op(1'b1, 3'b101, 32'd5, 32'd0, 4, 0, -1, 1'b0);
      run_op(1'b1, 3'b111, 32'd5, 32'd0, 4, 0, -1, 1'b0);
      // Flush while result is waiting in DONE.
      run_op(1'b0, 3'b011, 32'h1234, 32'h10, 3, 2, -1, 1'b1);
      idle_cycle();
      idle_cycle();

      // Randomized ops.
      for (int i = 0; i < 40; i++) begin
         dv = 1'($urandom_range(0, 1));
         f3 = {dv, 2'($urandom_range(0, 3))};
         a  = $urandom;
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         d  = int'($urandom_range(1, 20));
         st = int'($urandom_range(0, 3));
         fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, d - 1)) : -1;
         fd = ($urandom_range(0, 5) == 0);
         run_op(dv, f3, a, b, d, st, fa, fd);
         repeat ($urandom_range(0, 2)) idle_cycle();
      end

      // Reset in the middle of a DIV, then a stale div_done.
      req_valid = 1'b1; req_is_div = 1'b1; req_funct3 = 3'b101;
      req_a = 32'h1234_5678; req_b = 32'h55;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check_eq("arst_start", 32'(unit_start), 32'd0);
      check_eq("arst_sel", 32'(unit_sel), 32'd0);
      check_eq("arst_funct3", 32'(unit_funct3), 32'd0);
      check_eq("arst_a", unit_a, 32'd0);
      check_eq("arst_b", unit_b, 32'd0);
      check_eq("arst_result", result, 32'd0);
      check_eq("arst_rv", 32'(result_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 1'b0;
      tick();
      div_done = 1'b1; unit_result = 32'hDEAD_BEEF;
      tick();
      div_done = 1'b0;
      check_eq("stale_rv", 32'(result_valid), 32'd0);
      check_eq("stale_result", result, 32'd0);
      check_eq("stale_start", 32'(unit_start), 32'd0);
      check_eq("stale_stall", 32'(func_stall), 32'd0);
      tick();
      check_eq("stale_rv_later", 32'(result_valid), 32'd0);
      run_op(1'b0, 3'b000, 32'd3, 32'd5, 1, 0, -1, 1'b0);

      // Timeout on the TIMEOUT=8 instance: no done ever arrives.
      do_reset();
      req_valid = 1'b1; req_is_div = 1'b0; req_funct3 = 3'b000; req_a = 32'd3; req_b = 32'd4;
      #1;
      check_eq("to_issue_stall", 32'(t8_func_stall), 32'd1);
      tick();
      for (int j = 0; j < 8; j++) begin
         check_eq("to_busy_start", 32'(t8_unit_start), 32'(j == 0));
         check_eq("to_busy_rv", 32'(t8_result_valid), 32'd0);
         check_eq("to_busy_err", 32'(t8_timeout_err), 32'd0);
         tick();
      end
      check_eq("to_err", 32'(t8_timeout_err), 32'd1);
      check_eq("to_result", t8_result, 32'd0);
      check_eq("to_rv", 32'(t8_result_valid), 32'd1);
      req_valid = 1'b0;
      tick();
      check_eq("to_idle_rv", 32'(t8_result_valid), 32'd0);
      repeat (3) tick();
      check_eq("to_sticky", 32'(t8_timeout_err), 32'd1);
      do_reset();
      check_eq("to_cleared", 32'(t8_timeout_err), 32'd0);

      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
